if_fetch_queue: RTL and testbench

// - Parametrised IF stage: DEPTH-entry in-order fetch queue between pre-IF/icache and ID.
// - Tracks up to MAX_OUT outstanding icache responses; after a flush, a counter drops every stale response.
// - Marks branch-shadow entries "unhit": they are still issued to ID, with inst forced to 0.
// - Replaces the single-entry IF register with its one-bit discard flag.

---
 rtl/if_fetch_queue_pkg.sv | 26 ++
 rtl/if_oldest_wait_pick.sv | 28 ++
 rtl/if_fetch_queue.sv | 183 ++++++++++++++++++
 tb/tb_if_fetch_queue.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the IF fetch queue: entry states, default widths, branch-shadow rule.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package if_fetch_queue_pkg;

  // Life cycle of one queue slot: free, waiting on icache data, or presentable to ID.
  typedef enum logic [1:0] {
    IFQ_EMPTY = 2'd0,
    IFQ_WAIT  = 2'd1,
    IFQ_READY = 2'd2
  } ifq_state_e;

  localparam int IFQ_PC_W   = 32;
  localparam int IFQ_INST_W = 32;
  localparam int IFQ_EXC_W  = 3;

  // An entry sits in a branch shadow when a resolved branch goes elsewhere than
  // its fall-through pc, or a likely branch is cleared and the entry is exactly
  // the fall-through (delay-slot) pc.
  function automatic logic branch_shadow(input logic is_fallthru,
                                         input logic branch_ready,
                                         input logic likely_clear);
    return (branch_ready && !is_fallthru) || (likely_clear && is_fallthru);
  endfunction

endpackage

// File: rtl/if_oldest_wait_pick.sv
// Picks the oldest WAIT slot, scanning from head forward with wrap-around.
// Latency: combinational.
// Backpressure: none; found=0 when no slot is waiting.
module if_oldest_wait_pick
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic [DEPTH-1:0] wait_flags,
  input  logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] idx,
  output logic             found
);

  // Scan from the youngest distance down so the slot closest to head wins last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (wait_flags[head + PTR_W'(i)]) begin
        idx   = head + PTR_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// In-order IF fetch queue between pre-IF/icache and ID, with stale-response discard after flush.
// Latency: a READY head is presented combinationally; a WAIT head is bypassed in the cycle its data returns.
// Backpressure: IF_allowin drops when full (unless popping) or when MAX_OUT responses are owed.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 4,
  parameter int PC_W    = IFQ_PC_W,
  parameter int INST_W  = IFQ_INST_W,
  parameter int EXC_W   = IFQ_EXC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              pre_IF_to_IF_valid,
  input  logic [PC_W-1:0]   pre_IF_pc,
  input  logic [EXC_W-1:0]  pre_IF_exc,
  input  logic              icache_data_ok,
  input  logic [INST_W-1:0] icache_rdata,
  input  logic              IF_branch_ready,
  input  logic              branch_likely_clear,
  input  logic [PC_W-1:0]   IF_branch_pc,
  input  logic              ID_allowin,
  output logic              IF_allowin,
  output logic              IF_ID_valid,
  output logic [PC_W-1:0]   IF_ID_pc,
  output logic [INST_W-1:0] IF_ID_inst,
  output logic [EXC_W-1:0]  IF_ID_exc,
  output logic              IF_ID_unhit,
  output logic              inst_req_busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [PTR_W:0] DEPTH_C   = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W:0] MAX_OUT_C = (CNT_W + 1)'(MAX_OUT);

  ifq_state_e        state_q [DEPTH];
  logic [PC_W-1:0]   pc_q    [DEPTH];
  logic [EXC_W-1:0]  exc_q   [DEPTH];
  logic [INST_W-1:0] inst_q  [DEPTH];
  logic [DEPTH-1:0]  unhit_q;

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W:0]    count;
  logic [CNT_W-1:0]  discard_cnt;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W:0]    pending;

  logic [DEPTH-1:0]  wait_flags;
  logic [DEPTH-1:0]  unhit_now;
  logic [PC_W-1:0]   fallthru_pc;
  logic [PTR_W-1:0]  fill_idx;
  logic              fill_found;
  logic              fill;
  logic              push;
  logic              pop;
  logic              push_is_exc;
  logic              push_unhit;
  logic              bypass;
  logic              head_unhit;

  if_oldest_wait_pick #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_pick (
    .wait_flags (wait_flags),
    .head       (head),
    .idx        (fill_idx),
    .found      (fill_found)
  );

  // Per-slot WAIT flags, outstanding count and this cycle's branch-shadow hits.
  always_comb begin
    wait_flags  = '0;
    unhit_now   = '0;
    wait_cnt    = '0;
    fallthru_pc = IF_branch_pc + PC_W'(4);
    for (int i = 0; i < DEPTH; i++) begin
      wait_flags[i] = (state_q[i] == IFQ_WAIT);
      wait_cnt      = wait_cnt + CNT_W'(wait_flags[i]);
      unhit_now[i]  = (state_q[i] != IFQ_EMPTY) &&
                      branch_shadow(pc_q[i] == fallthru_pc, IF_branch_ready, branch_likely_clear);
    end
  end

  // Handshakes, head presentation and the response-routing decision.
  always_comb begin
    pending     = {1'b0, discard_cnt} + {1'b0, wait_cnt};
    push_is_exc = |pre_IF_exc;
    push_unhit  = branch_shadow(pre_IF_pc == fallthru_pc, IF_branch_ready, branch_likely_clear);
    // Stale responses are always the oldest ones owed, so they are burned first.
    fill        = icache_data_ok && (discard_cnt == '0) && fill_found;
    bypass      = (state_q[head] == IFQ_WAIT) && icache_data_ok && (discard_cnt == '0);
    head_unhit  = unhit_q[head] | unhit_now[head];

    IF_ID_valid = !reset && !flush && ((state_q[head] == IFQ_READY) || bypass);
    pop         = IF_ID_valid && ID_allowin;
    IF_allowin  = !reset && !flush && ((count < DEPTH_C) || pop) &&
                  ((pending < MAX_OUT_C) || push_is_exc);
    push        = pre_IF_to_IF_valid && IF_allowin;

    IF_ID_pc      = IF_ID_valid ? pc_q[head]  : '0;
    IF_ID_exc     = IF_ID_valid ? exc_q[head] : '0;
    IF_ID_unhit   = IF_ID_valid && head_unhit;
    IF_ID_inst    = (IF_ID_valid && !head_unhit) ? (bypass ? icache_rdata : inst_q[head]) : '0;
    inst_req_busy = (pending != '0);
  end

  // Pointers, occupancy and the stale-response counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      discard_cnt <= '0;
    end else if (flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      // A response arriving in the flush cycle already pays off one owed slot.
      discard_cnt <= CNT_W'(pending - (CNT_W + 1)'(icache_data_ok));
    end else begin
      if (icache_data_ok && (discard_cnt != '0)) begin
        discard_cnt <= discard_cnt - 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      if (push) begin
        tail <= tail + 1'b1;
      end
      count <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    end
  end

  // Slot storage; write order fill -> pop -> push lets a full-queue push reuse the popped slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      unhit_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= IFQ_EMPTY;
        pc_q[i]    <= '0;
        exc_q[i]   <= '0;
        inst_q[i]  <= '0;
      end
    end else if (flush) begin
      unhit_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= IFQ_EMPTY;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (unhit_now[i]) begin
          unhit_q[i] <= 1'b1;
        end
      end
      if (fill) begin
        state_q[fill_idx] <= IFQ_READY;
        inst_q[fill_idx]  <= icache_rdata;
      end
      if (pop) begin
        state_q[head] <= IFQ_EMPTY;
        unhit_q[head] <= 1'b0;
      end
      if (push) begin
        // Exception entries need no icache data and carry a zero instruction.
        state_q[tail] <= push_is_exc ? IFQ_READY : IFQ_WAIT;
        pc_q[tail]    <= pre_IF_pc;
        exc_q[tail]   <= pre_IF_exc;
        inst_q[tail]  <= '0;
        unhit_q[tail] <= push_unhit;
      end
    end
  end

  // A response with nothing owed means the icache and this queue disagree.
  a_no_stray_rsp: assert property (@(posedge clk) disable iff (reset)
                                   !(icache_data_ok && (pending == '0)));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue against a queue-based reference model.
// Latency: outputs sampled on the falling edge, model advanced on the rising edge.
// Backpressure: the bench plays icache and only returns data that the model says is owed.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        reset, flush, pre_v, data_ok, br_ready, br_likely, id_allowin;
  logic [31:0] pre_pc, rdata, br_pc;
  logic [2:0]  pre_exc;
  logic        allowin, id_valid, id_unhit, busy;
  logic [31:0] id_pc, id_inst;
  logic [2:0]  id_exc;

  if_fetch_queue dut (
    .clk                 (clk),
    .reset               (reset),
    .flush               (flush),
    .pre_IF_to_IF_valid  (pre_v),
    .pre_IF_pc           (pre_pc),
    .pre_IF_exc          (pre_exc),
    .icache_data_ok      (data_ok),
    .icache_rdata        (rdata),
    .IF_branch_ready     (br_ready),
    .branch_likely_clear (br_likely),
    .IF_branch_pc        (br_pc),
    .ID_allowin          (id_allowin),
    .IF_allowin          (allowin),
    .IF_ID_valid         (id_valid),
    .IF_ID_pc            (id_pc),
    .IF_ID_inst          (id_inst),
    .IF_ID_exc           (id_exc),
    .IF_ID_unhit         (id_unhit),
    .inst_req_busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: the queue contents as a list, plus stale responses still owed.
  typedef struct {
    logic [31:0] pc;
    logic [2:0]  exc;
    logic [31:0] inst;
    bit          have;
    bit          unhit;
  } ent_t;

  ent_t        mq[$];
  int          m_discard;
  bit          m_pop, m_push;
  logic [70:0] exp_vec, got_vec;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic int m_pending();
    int p = m_discard;
    foreach (mq[i]) if (!mq[i].have) p++;
    return p;
  endfunction

  function automatic bit shadow(logic [31:0] pc);
    return (br_ready && pc != br_pc + 32'd4) || (br_likely && pc == br_pc + 32'd4);
  endfunction

  task automatic idle();
    pre_v = 0; pre_pc = '0; pre_exc = '0; data_ok = 0; rdata = '0; flush = 0;
    br_ready = 0; br_likely = 0; br_pc = '0; id_allowin = 0;
  endtask

  // Expected outputs for the inputs currently applied; also samples the DUT.
  task automatic predict();
    bit v, u, al;
    logic [31:0] pc, ins;
    logic [2:0] ex;
    @(negedge clk);
    v = 0; u = 0; pc = '0; ins = '0; ex = '0;
    if (!flush && mq.size() > 0) begin
      v = mq[0].have || (data_ok && m_discard == 0);
      if (v) begin
        u  = mq[0].unhit || shadow(mq[0].pc);
        pc = mq[0].pc;
        ex = mq[0].exc;
        if (!u) ins = mq[0].have ? mq[0].inst : rdata;
      end
    end
    m_pop  = v && id_allowin;
    al     = !flush && (mq.size() < 4 || m_pop) && (m_pending() < 4 || pre_exc != 0);
    m_push = pre_v && al;
    exp_vec = {al, v, u, m_pending() != 0, pc, ins, ex};
    got_vec = {allowin, id_valid, id_unhit, busy, id_pc, id_inst, id_exc};
  endtask

  // Advance the model by one cycle and move to the next input slot.
  task automatic commit();
    bit done;
    if (flush) begin
      m_discard = m_pending() - int'(data_ok);
      mq.delete();
    end else begin
      foreach (mq[i]) if (shadow(mq[i].pc)) mq[i].unhit = 1;
      if (data_ok) begin
        if (m_discard > 0) m_discard--;
        else begin
          done = 0;
          foreach (mq[i]) if (!done && !mq[i].have) begin
            mq[i].have = 1; mq[i].inst = rdata; done = 1;
          end
        end
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back('{pc: pre_pc, exc: pre_exc, inst: 32'h0,
                                 have: (pre_exc != 0), unhit: shadow(pre_pc)});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    mq.delete(); m_discard = 0;
    predict();
    n_checks++;
    if (got_vec !== exp_vec) $display("FAIL reset outputs: got %h expected %h", got_vec, exp_vec);
    else n_pass++;
    n_checks++;
    if (dut.discard_cnt !== '0) $display("FAIL reset discard_cnt: got %0d expected 0", dut.discard_cnt);
    else n_pass++;
    commit();
  endtask

  task automatic test_in_order();
    for (int c = 0; c < 7; c++) begin
      idle(); id_allowin = 1; rdata = $urandom;
      if (c < 3) begin pre_v = 1; pre_pc = 32'h100 + 32'(4 * c); end
      data_ok = (c >= 1 && c <= 3) && m_pending() > 0;
      predict();
      n_checks++;
      if (got_vec !== exp_vec) $display("FAIL in_order c%0d: got %h expected %h", c, got_vec, exp_vec);
      else n_pass++;
      commit();
    end
    n_checks++;
    if (dut.wait_cnt !== '0) $display("FAIL in_order wait_cnt: got %0d expected 0", dut.wait_cnt);
    else n_pass++;
  endtask

  task automatic test_full();
    for (int c = 0; c < 12; c++) begin
      idle(); rdata = $urandom;
      if (c <= 3) begin pre_v = 1; pre_pc = 32'h300 + 32'(4 * c); end
      if (c == 5 || c == 6) begin pre_v = 1; pre_pc = 32'h310; end
      if (c >= 6) id_allowin = 1;
      data_ok = ((c >= 1 && c <= 4) || c == 8) && m_pending() > 0;
      predict();
      n_checks++;
      if (got_vec !== exp_vec) $display("FAIL full c%0d: got %h expected %h", c, got_vec, exp_vec);
      else n_pass++;
      n_checks++;
      if (int'(dut.count) != mq.size()) $display("FAIL full count c%0d: got %0d expected %0d", c, dut.count, mq.size());
      else n_pass++;
      commit();
    end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 12; c++) begin
      idle(); rdata = $urandom;
      case (c)
        0: begin pre_v = 1; pre_pc = 32'h500; end
        1: begin pre_v = 1; pre_pc = 32'h504; end
        2: flush = 1;
        3: begin data_ok = 1; pre_v = 1; pre_pc = 32'h200; end
        4: data_ok = 1;
        5: begin data_ok = 1; id_allowin = 1; end
        7: begin pre_v = 1; pre_pc = 32'h600; end
        8: begin pre_v = 1; pre_pc = 32'h604; end
        9: begin flush = 1; data_ok = 1; end
        10: data_ok = 1;
        default: ;
      endcase
      data_ok = data_ok && m_pending() > 0;
      predict();
      n_checks++;
      if (got_vec !== exp_vec) $display("FAIL flush c%0d: got %h expected %h", c, got_vec, exp_vec);
      else n_pass++;
      n_checks++;
      if (int'(dut.discard_cnt) != m_discard) $display("FAIL flush discard_cnt c%0d: got %0d expected %0d", c, dut.discard_cnt, m_discard);
      else n_pass++;
      commit();
    end
  endtask

  task automatic test_unhit();
    for (int c = 0; c < 20; c++) begin
      int k;
      k = c % 10;
      idle(); rdata = $urandom; br_pc = 32'h400;
      if (k <= 2) begin pre_v = 1; pre_pc = 32'h400 + 32'(4 * k); end
      if (k == 4) begin br_ready = (c < 10); br_likely = (c >= 10); end
      if (k >= 5) id_allowin = 1;
      data_ok = (k >= 1 && k <= 3) && m_pending() > 0;
      predict();
      n_checks++;
      if (got_vec !== exp_vec) $display("FAIL unhit c%0d: got %h expected %h", c, got_vec, exp_vec);
      else n_pass++;
      commit();
    end
  endtask

  task automatic test_exc();
    for (int c = 0; c < 7; c++) begin
      idle(); rdata = $urandom;
      if (c == 0) begin pre_v = 1; pre_pc = 32'h700; end
      if (c == 1) begin pre_v = 1; pre_pc = 32'h704; pre_exc = 3'b001; end
      if (c >= 3) id_allowin = 1;
      data_ok = (c == 2) && m_pending() > 0;
      predict();
      n_checks++;
      if (got_vec !== exp_vec) $display("FAIL exc c%0d: got %h expected %h", c, got_vec, exp_vec);
      else n_pass++;
      commit();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle();
      rdata      = $urandom;
      pre_v      = ($urandom_range(0, 3) != 0);
      pre_pc     = 32'h800 + 32'(4 * $urandom_range(0, 7));
      pre_exc    = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      id_allowin = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 24) == 0);
      br_pc      = 32'h800 + 32'(4 * $urandom_range(0, 7));
      br_ready   = ($urandom_range(0, 9) == 0);
      br_likely  = !br_ready && ($urandom_range(0, 9) == 0);
      data_ok    = ($urandom_range(0, 2) != 0) && m_pending() > 0;
      predict();
      n_checks++;
      if (got_vec !== exp_vec) $display("FAIL random c%0d: got %h expected %h", c, got_vec, exp_vec);
      else n_pass++;
      commit();
    end
  endtask

  task automatic test_reset_mid();
    // Drain anything left over so three fresh requests are outstanding.
    for (int c = 0; c < 6; c++) begin
      idle(); id_allowin = 1; rdata = $urandom;
      data_ok = m_pending() > 0;
      predict();
      commit();
    end
    for (int c = 0; c < 3; c++) begin
      idle(); pre_v = 1; pre_pc = 32'h900 + 32'(4 * c);
      predict();
      n_checks++;
      if (got_vec !== exp_vec) $display("FAIL reset_mid fill c%0d: got %h expected %h", c, got_vec, exp_vec);
      else n_pass++;
      commit();
    end
    idle();
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    mq.delete(); m_discard = 0;
    predict();
    n_checks++;
    if (got_vec !== exp_vec) $display("FAIL reset_mid outputs: got %h expected %h", got_vec, exp_vec);
    else n_pass++;
    n_checks++;
    if (dut.discard_cnt !== '0) $display("FAIL reset_mid discard_cnt: got %0d expected 0", dut.discard_cnt);
    else n_pass++;
    commit();
  endtask

  initial begin
    idle();
    reset = 1;
    m_discard = 0;
    test_reset();
    test_in_order();
    test_full();
    test_flush();
    test_unhit();
    test_exc();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
